riscv_fetchq: RTL and testbench

Instruction fetch queue directly downstream of the PC register. Each cycle it turns the current PC into an instruction-memory request. It tracks in-flight requests and buffers returned instructions with their PCs in an in-order queue that feeds decode. It also generates the PC-register stall and discards stale responses after a redirect flush.

---
 rtl/riscv_fetchq.sv | 187 ++++++++++++++++++
 tb/tb_riscv_fetchq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetchq.sv
// Instruction fetch queue: turns the PC into in-order imem requests and buffers {pc, inst} for decode.
// Latency: response to o_riscv_fetchq_valid is 1 cycle (0 cycles when RISCV_FETCHQ_BYPASS_EN is defined and the queue holds nothing filled).
// Backpressure: requests stop once in-flight + buffered + to-be-dropped reaches DEPTH; stallpc holds the PC until a request is granted.
//
// Optional feature macro: RISCV_FETCHQ_BYPASS_EN (combinational response-to-decode bypass).
//
// Ports:
//   i_riscv_fetchq_clk / i_riscv_fetchq_rst       clock (rising edge), async active-high reset
//   i_riscv_fetchq_pc                             current PC from the PC register
//   o_riscv_fetchq_stallpc                        hold the PC register (no request accepted this cycle)
//   o_riscv_fetchq_memreq / _memaddr / i_..._memgnt   imem request handshake
//   i_riscv_fetchq_memrvalid / _memrdata          in-order imem responses
//   i_riscv_fetchq_flush                          redirect: discard queued and in-flight fetches
//   i_riscv_fetchq_stalldec                       decode cannot accept this cycle
//   o_riscv_fetchq_valid / _inst / _instpc        head instruction to decode
module riscv_fetchq #(
  parameter int WIDTH = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_riscv_fetchq_clk,
  input  logic             i_riscv_fetchq_rst,
  input  logic [WIDTH-1:0] i_riscv_fetchq_pc,
  output logic             o_riscv_fetchq_stallpc,
  output logic             o_riscv_fetchq_memreq,
  output logic [WIDTH-1:0] o_riscv_fetchq_memaddr,
  input  logic             i_riscv_fetchq_memgnt,
  input  logic             i_riscv_fetchq_memrvalid,
  input  logic [ILEN-1:0]  i_riscv_fetchq_memrdata,
  input  logic             i_riscv_fetchq_flush,
  input  logic             i_riscv_fetchq_stalldec,
  output logic             o_riscv_fetchq_valid,
  output logic [ILEN-1:0]  o_riscv_fetchq_inst,
  output logic [WIDTH-1:0] o_riscv_fetchq_instpc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  // Queue storage
  logic [WIDTH-1:0] pc_q     [DEPTH];
  logic [WIDTH-1:0] pc_d     [DEPTH];
  logic [ILEN-1:0]  inst_q   [DEPTH];
  logic [ILEN-1:0]  inst_d   [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  // Pointers wrap naturally at DEPTH (power of two)
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;

  // alloc_cnt: entries owned by the queue (issued, not yet popped)
  // unfilled_cnt: subset of those still waiting for their response
  // drop_cnt: responses still owed for requests issued before a flush
  logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0] unfilled_cnt_q, unfilled_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW:0]   credit_used;
  logic [CW-1:0] drop_sum;
  logic          issue;
  logic          rsp_drop;
  logic          rsp_fill;
  logic          bypass;
  logic          pop;
  logic          bypass_pop;
  logic          pop_any;

  assign credit_used = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};

  assign o_riscv_fetchq_memreq  = ~i_riscv_fetchq_rst & ~i_riscv_fetchq_flush & (credit_used < DEPTH_C);
  assign o_riscv_fetchq_memaddr = i_riscv_fetchq_pc;
  assign issue                  = o_riscv_fetchq_memreq & i_riscv_fetchq_memgnt;
  assign o_riscv_fetchq_stallpc = ~issue;

  // Responses owed to pre-flush requests are consumed first; a response with
  // nothing outstanding is a protocol error and is ignored.
  assign rsp_drop = i_riscv_fetchq_memrvalid & (drop_cnt_q != '0);
  assign rsp_fill = i_riscv_fetchq_memrvalid & (drop_cnt_q == '0) & (unfilled_cnt_q != '0);

`ifdef RISCV_FETCHQ_BYPASS_EN
  logic [CW-1:0] filled_cnt;
  assign filled_cnt = alloc_cnt_q - unfilled_cnt_q;
  // With nothing filled, the oldest unfilled entry is the head, so the
  // response can be forwarded straight to decode alongside the head pc.
  assign bypass = ~i_riscv_fetchq_rst & ~i_riscv_fetchq_flush & rsp_fill & (filled_cnt == '0);
`else
  assign bypass = 1'b0;
`endif

  assign o_riscv_fetchq_valid  = filled_q[head_q] | bypass;
  assign o_riscv_fetchq_inst   = bypass ? i_riscv_fetchq_memrdata : inst_q[head_q];
  assign o_riscv_fetchq_instpc = pc_q[head_q];

  assign pop        = filled_q[head_q] & ~i_riscv_fetchq_stalldec;
  assign bypass_pop = bypass & ~i_riscv_fetchq_stalldec;
  assign pop_any    = pop | bypass_pop;

  // Every in-flight response is either owed as a drop or waiting in an entry;
  // a flush turns all waiting entries into drops.
  assign drop_sum = drop_cnt_q + unfilled_cnt_q;

  always_comb begin
    pc_d           = pc_q;
    inst_d         = inst_q;
    filled_d       = filled_q;
    head_d         = head_q;
    alloc_d        = alloc_q;
    fill_d         = fill_q;
    alloc_cnt_d    = alloc_cnt_q;
    unfilled_cnt_d = unfilled_cnt_q;
    drop_cnt_d     = drop_cnt_q;

    if (i_riscv_fetchq_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_d[i]   = '0;
        inst_d[i] = '0;
      end
      filled_d       = '0;
      head_d         = '0;
      alloc_d        = '0;
      fill_d         = '0;
      alloc_cnt_d    = '0;
      unfilled_cnt_d = '0;
      // A response landing in the flush cycle is discarded and settles one owed drop.
      if (i_riscv_fetchq_memrvalid && (drop_sum != '0)) begin
        drop_cnt_d = drop_sum - CW'(1);
      end else begin
        drop_cnt_d = drop_sum;
      end
    end else begin
      if (issue) begin
        pc_d[alloc_q]     = i_riscv_fetchq_pc;
        inst_d[alloc_q]   = '0;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + PW'(1);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (rsp_fill) begin
        fill_d = fill_q + PW'(1);
        // A bypassed entry consumed this cycle never becomes filled.
        if (!bypass_pop) begin
          inst_d[fill_q]   = i_riscv_fetchq_memrdata;
          filled_d[fill_q] = 1'b1;
        end
      end
      if (pop_any) begin
        pc_d[head_q]     = '0;
        inst_d[head_q]   = '0;
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      alloc_cnt_d    = alloc_cnt_q + CW'(issue) - CW'(pop_any);
      unfilled_cnt_d = unfilled_cnt_q + CW'(issue) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge i_riscv_fetchq_clk or posedge i_riscv_fetchq_rst) begin
    if (i_riscv_fetchq_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      filled_q       <= '0;
      head_q         <= '0;
      alloc_q        <= '0;
      fill_q         <= '0;
      alloc_cnt_q    <= '0;
      unfilled_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      filled_q       <= filled_d;
      head_q         <= head_d;
      alloc_q        <= alloc_d;
      fill_q         <= fill_d;
      alloc_cnt_q    <= alloc_cnt_d;
      unfilled_cnt_q <= unfilled_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_fetchq.sv
// Bench for riscv_fetchq: memory model + PC register model + in-order scoreboard.
// Latency: expected outputs are compared whenever the DUT presents o_riscv_fetchq_valid.
// Backpressure: stalldec/memgnt/latency are driven by directed sequences and a random phase.
module tb_riscv_fetchq;

  localparam int WIDTH = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

`ifdef RISCV_FETCHQ_BYPASS_EN
  localparam int RSP_LAT = 1;
`else
  localparam int RSP_LAT = 2;
`endif

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          ready;
    bit          stale;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] pc;
  logic             stallpc;
  logic             memreq;
  logic [WIDTH-1:0] memaddr;
  logic             memgnt;
  logic             rvalid;
  logic [ILEN-1:0]  rdata;
  logic             flush;
  logic             stalldec;
  logic             valid;
  logic [ILEN-1:0]  inst;
  logic [WIDTH-1:0] instpc;

  riscv_fetchq #(.WIDTH(WIDTH), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .i_riscv_fetchq_clk       (clk),
    .i_riscv_fetchq_rst       (rst),
    .i_riscv_fetchq_pc        (pc),
    .o_riscv_fetchq_stallpc   (stallpc),
    .o_riscv_fetchq_memreq    (memreq),
    .o_riscv_fetchq_memaddr   (memaddr),
    .i_riscv_fetchq_memgnt    (memgnt),
    .i_riscv_fetchq_memrvalid (rvalid),
    .i_riscv_fetchq_memrdata  (rdata),
    .i_riscv_fetchq_flush     (flush),
    .i_riscv_fetchq_stalldec  (stalldec),
    .o_riscv_fetchq_valid     (valid),
    .o_riscv_fetchq_inst      (inst),
    .o_riscv_fetchq_instpc    (instpc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  req_t        pend_q[$];
  exp_t        exp_q[$];
  logic [63:0] issue_log[$];
  int          stale_cnt = 0;
  int          mem_lat = 1;
  int          cyc = 0;
  int          n_issue = 0;
  int          n_out = 0;
  int          first_issue_cyc = -1;
  int          first_valid_cyc = -1;
  logic [63:0] first_valid_pc = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {a[11:0], 20'h00013};
  endfunction

  function automatic int pend_sum();
    return exp_q.size() + pend_q.size();
  endfunction

  // One clock cycle: check at negedge, update models, then advance past posedge.
  task automatic cycle();
    logic exp_req;
    logic issue;
    logic pc_adv;
    req_t r;
    exp_t e;
    pc_adv = 1'b0;
    @(negedge clk);
    exp_req = !rst && !flush && ((exp_q.size() + stale_cnt) < DEPTH);
    chk("memreq", memreq, exp_req);
    chk("stallpc", stallpc, !(exp_req && memgnt));
    if (memreq) chk("memaddr", memaddr, pc);
    if (rst) begin
      chk("valid_in_rst", valid, 1'b0);
    end else if (valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1'b1, 1'b0);
      end else begin
        chk("instpc", instpc, exp_q[0].pc);
        chk("inst", inst, exp_q[0].inst);
        if (first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          first_valid_pc  = instpc;
        end
        if (!stalldec && !flush) begin
          e = exp_q.pop_front();
          n_out++;
        end
      end
    end
    if (rvalid && pend_q.size() != 0) begin
      r = pend_q.pop_front();
      if (r.stale) stale_cnt--;
    end
    issue = memreq && memgnt;
    if (issue) begin
      r.addr  = pc;
      r.data  = inst_of(pc);
      r.ready = cyc + mem_lat;
      r.stale = 1'b0;
      pend_q.push_back(r);
      e.pc   = pc;
      e.inst = inst_of(pc);
      exp_q.push_back(e);
      issue_log.push_back(pc);
      n_issue++;
      if (first_issue_cyc < 0) first_issue_cyc = cyc;
      pc_adv = 1'b1;
    end
    if (flush) begin
      for (int k = 0; k < pend_q.size(); k++) begin
        r = pend_q[k];
        r.stale = 1'b1;
        r.data  = 32'hDEAD0001 + 32'(k);
        pend_q[k] = r;
      end
      stale_cnt = pend_q.size();
      exp_q.delete();
    end
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      stale_cnt = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pc_adv) pc = pc + 64'd4;
    if (!rst && pend_q.size() != 0 && pend_q[0].ready <= cyc) begin
      rvalid = 1'b1;
      rdata  = pend_q[0].data;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  endtask

  task automatic clear_trackers();
    n_issue = 0;
    n_out = 0;
    issue_log.delete();
    first_issue_cyc = -1;
    first_valid_cyc = -1;
    first_valid_pc = '0;
  endtask

  task automatic restart(input logic [63:0] pc0);
    rst = 1'b1;
    rvalid = 1'b0;
    rdata = '0;
    flush = 1'b0;
    stalldec = 1'b0;
    memgnt = 1'b0;
    pend_q.delete();
    exp_q.delete();
    stale_cnt = 0;
    cycle();
    rst = 1'b0;
    pc = pc0;
    clear_trackers();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    memgnt = 1'b0;
    stalldec = 1'b0;
    flush = 1'b0;
    while (pend_sum() != 0 && n < 60) begin
      cycle();
      n++;
    end
    chk(tag, pend_sum(), 0);
  endtask

  initial begin
    rst = 1'b0;
    pc = 64'h80000;
    memgnt = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    flush = 1'b0;
    stalldec = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_valid", valid, 1'b0);
    chk("reset_inst", inst, 32'h0);
    chk("reset_instpc", instpc, 64'h0);
    chk("reset_memreq", memreq, 1'b0);
    chk("reset_stallpc", stallpc, 1'b1);

    // Streaming: one output per cycle, in PC order
    restart(64'h80000);
    memgnt = 1'b1;
    mem_lat = 1;
    repeat (10) cycle();
    chk("first_valid_latency", 64'(first_valid_cyc - first_issue_cyc), 64'(RSP_LAT));
    chk("stream_issues", n_issue, 10);
    chk("stream_outputs", n_out, 10 - RSP_LAT);
    drain("drain_stream");

    // Decode stalled: queue fills after DEPTH issues, then resumes
    restart(64'h80000);
    memgnt = 1'b1;
    stalldec = 1'b1;
    repeat (8) cycle();
    chk("full_issues", n_issue, 4);
    chk("full_pc_held", pc, 64'h80010);
    chk("full_memreq", memreq, 1'b0);
    chk("full_stallpc", stallpc, 1'b1);
    stalldec = 1'b0;
    for (int i = 0; i < 20 && issue_log.size() <= 4; i++) cycle();
    chk("resume_seen", issue_log.size() > 4, 1'b1);
    if (issue_log.size() > 4) chk("resume_addr", issue_log[4], 64'h80010);
    repeat (4) cycle();
    drain("drain_full");

    // Reset mid-stream with 3 filled entries queued
    restart(64'h80000);
    memgnt = 1'b1;
    stalldec = 1'b1;
    repeat (4) cycle();
    chk("pre_rst_valid", valid, 1'b1);
    rst = 1'b1;
    rvalid = 1'b0;
    rdata = '0;
    pend_q.delete();
    exp_q.delete();
    stale_cnt = 0;
    #1;
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_memreq", memreq, 1'b0);
    chk("midrst_stallpc", stallpc, 1'b1);
    chk("midrst_inst", inst, 32'h0);
    cycle();
    rst = 1'b0;
    pc = 64'h80000;
    memgnt = 1'b1;
    stalldec = 1'b0;
    clear_trackers();
    #1;
    chk("rel_memreq", memreq, 1'b1);
    chk("rel_memaddr", memaddr, 64'h80000);
    chk("rel_stallpc", stallpc, 1'b0);
    repeat (6) cycle();
    drain("drain_midrst");

    // Flush with 2 requests in flight, redirect to 0x90000
    restart(64'h80000);
    memgnt = 1'b1;
    mem_lat = 3;
    repeat (2) cycle();
    flush = 1'b1;
    pc = 64'h90000;
    cycle();
    flush = 1'b0;
    first_valid_cyc = -1;
    repeat (10) cycle();
    chk("flush_first_pc", first_valid_pc, 64'h90000);
    drain("drain_flush2");

    // Flush coincident with a response, 3 in flight: exactly 2 more dropped
    restart(64'h80000);
    memgnt = 1'b1;
    mem_lat = 3;
    repeat (3) cycle();
    flush = 1'b1;
    pc = 64'hA0000;
    cycle();
    flush = 1'b0;
    first_valid_cyc = -1;
    repeat (10) cycle();
    chk("flush_rsp_first_pc", first_valid_pc, 64'hA0000);
    drain("drain_flush3");

    // No grant for 5 cycles, then a single grant
    restart(64'h80000);
    mem_lat = 1;
    memgnt = 1'b0;
    repeat (5) cycle();
    chk("nogrant_issues", n_issue, 0);
    memgnt = 1'b1;
    cycle();
    memgnt = 1'b0;
    repeat (3) cycle();
    chk("single_issue", n_issue, 1);
    if (issue_log.size() > 0) chk("single_issue_addr", issue_log[0], 64'h80000);
    drain("drain_nogrant");

    // Random grant / decode stall / latency / flush mix
    restart(64'h80000);
    for (int i = 0; i < 400; i++) begin
      memgnt   = ($urandom_range(0, 3) != 0);
      stalldec = ($urandom_range(0, 9) < 3);
      mem_lat  = $urandom_range(1, 3);
      if ($urandom_range(0, 31) == 0) begin
        flush = 1'b1;
        pc = 64'h100000 + 64'($urandom_range(0, 255) << 2);
      end else begin
        flush = 1'b0;
      end
      cycle();
    end
    flush = 1'b0;
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
